rr_burst_scheduler: RTL and testbench

//  Round-robin scheduler sharing one burst-processing resource among N requesters.

---
 rtl/rr_burst_scheduler_if.sv | 25 ++
 rtl/rr_burst_scheduler.sv | 142 ++++++++++++++
 tb/tb_rr_burst_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rr_burst_scheduler_if.sv
// Requester/resource bundle for the round-robin burst scheduler.
// The master side drives requests and done beats; the slave side is the scheduler.
interface rr_burst_scheduler_if #(
    parameter int N      = 4,
    parameter int SIZE_W = 3
);
    logic [N-1:0]        req;
    logic [N*SIZE_W-1:0] size;
    logic                done;
    logic [N-1:0]        resp;
    logic                start;
    logic                busy;
    logic [2:0]          owner;
    logic                abort;

    modport master (
        output req, size, done,
        input  resp, start, busy, owner, abort
    );

    modport slave (
        input  req, size, done,
        output resp, start, busy, owner, abort
    );
endinterface

// File: rtl/rr_burst_scheduler.sv
// Round-robin scheduler sharing one burst resource among N requesters,
// holding each grant for `size` done beats with a watchdog abort.
module rr_burst_scheduler #(
    parameter int N       = 4,
    parameter int SIZE_W  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    rr_burst_scheduler_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [SIZE_W-1:0] cnt_q, cnt_d;
    logic [WW-1:0]     wd_q, wd_d;
    logic [N-1:0]      resp_q, resp_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              abort_q, abort_d;
    logic [2:0]        owner_q, owner_d;

    logic [N-1:0]      elig;
    logic              found;
    logic [PW-1:0]     win;
    logic [PW-1:0]     cand;
    logic [SIZE_W-1:0] win_size;

    // Zero-size requests can never complete a burst, so they are not eligible.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = bus.req[i] & (|bus.size[i*SIZE_W +: SIZE_W]);
        end
    end

    // Search starts just after the last grantee, so it has lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_size = bus.size[int'(win)*SIZE_W +: SIZE_W];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        resp_d  = resp_q;
        busy_d  = busy_q;
        owner_d = owner_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    resp_d  = N'(1) << win;
                    owner_d = 3'(win);
                    ptr_d   = win;
                    cnt_d   = win_size;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                state_d = BUSY;
                wd_d    = '0;
            end
            BUSY: begin
                if (bus.done) begin
                    wd_d = '0;
                    if (cnt_q == SIZE_W'(1)) begin
                        state_d = IDLE;
                        resp_d  = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - SIZE_W'(1);
                    end
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    resp_d  = '0;
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    wd_d    = '0;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                resp_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= PW'(N - 1);
            cnt_q   <= '0;
            wd_q    <= '0;
            resp_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            resp_q  <= resp_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
            owner_q <= owner_d;
        end
    end

    assign bus.resp  = resp_q;
    assign bus.start = start_q;
    assign bus.busy  = busy_q;
    assign bus.abort = abort_q;
    assign bus.owner = owner_q;
endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed bench for rr_burst_scheduler with hand-computed expectations.
module tb_rr_burst_scheduler;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    rr_burst_scheduler_if #(.N(4), .SIZE_W(3)) bus ();

    rr_burst_scheduler #(.N(4), .SIZE_W(3), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_size(input logic [2:0] s3, input logic [2:0] s2,
                            input logic [2:0] s1, input logic [2:0] s0);
        bus.size = {s3, s2, s1, s0};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.req  = '0;
        bus.size = '0;
        bus.done = 1'b0;
        #3;
        chk("rst_resp", 32'(bus.resp), 0);
        chk("rst_start", 32'(bus.start), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_abort", 32'(bus.abort), 0);
        chk("rst_owner", 32'(bus.owner), 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
        chk("idle_resp", 32'(bus.resp), 0);

        // 1: single one-beat burst
        bus.req = 4'b0001;
        set_size(0, 0, 0, 1);
        bus.done = 1'b1;
        tick();
        chk("t1_resp_g", 32'(bus.resp), 4'b0001);
        chk("t1_start_g", 32'(bus.start), 1);
        chk("t1_busy_g", 32'(bus.busy), 1);
        bus.req = '0;
        tick();
        chk("t1_resp_b", 32'(bus.resp), 4'b0001);
        chk("t1_start_b", 32'(bus.start), 0);
        tick();
        chk("t1_resp_end", 32'(bus.resp), 0);
        chk("t1_busy_end", 32'(bus.busy), 0);
        bus.done = 1'b0;

        // 2: two requesters, 4-beat then 2-beat
        do_reset();
        bus.req = 4'b0011;
        set_size(0, 0, 2, 4);
        bus.done = 1'b1;
        tick();
        chk("t2_resp0", 32'(bus.resp), 4'b0001);
        chk("t2_start0", 32'(bus.start), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("t2_resp0_last", 32'(bus.resp), 4'b0001);
        tick();
        chk("t2_resp0_end", 32'(bus.resp), 0);
        chk("t2_owner_hold", 32'(bus.owner), 0);
        tick();
        chk("t2_resp1", 32'(bus.resp), 4'b0010);
        chk("t2_owner1", 32'(bus.owner), 1);
        tick();
        tick();
        chk("t2_resp1_last", 32'(bus.resp), 4'b0010);
        bus.req = '0;
        tick();
        chk("t2_resp1_end", 32'(bus.resp), 0);
        bus.done = 1'b0;

        // 3: all requesting, rotation 0,1,2,3,0
        do_reset();
        bus.req = 4'b1111;
        set_size(1, 1, 1, 1);
        bus.done = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("t3_resp", 32'(bus.resp), 32'(4'b0001 << (g % 4)));
            chk("t3_owner", 32'(bus.owner), 32'(g % 4));
            chk("t3_start", 32'(bus.start), 1);
            tick();
            tick();
            chk("t3_release", 32'(bus.resp), 0);
            if (g == 4) bus.req = '0;
        end
        bus.done = 1'b0;

        // 4: watchdog abort, no done
        bus.req = 4'b0100;
        set_size(0, 3, 0, 0);
        tick();
        chk("t4_resp", 32'(bus.resp), 4'b0100);
        bus.req = '0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("t4_busy_pre", 32'(bus.busy), 1);
        chk("t4_abort_pre", 32'(bus.abort), 0);
        tick();
        chk("t4_abort", 32'(bus.abort), 1);
        chk("t4_resp_ab", 32'(bus.resp), 0);
        chk("t4_busy_ab", 32'(bus.busy), 0);
        chk("t4_owner", 32'(bus.owner), 2);
        tick();
        chk("t4_abort_pulse", 32'(bus.abort), 0);

        // 5: zero-size requester ignored
        bus.req = 4'b0011;
        set_size(0, 0, 2, 0);
        bus.done = 1'b1;
        tick();
        chk("t5_resp", 32'(bus.resp), 4'b0010);
        chk("t5_owner", 32'(bus.owner), 1);
        tick();
        tick();
        tick();
        chk("t5_end", 32'(bus.resp), 0);
        bus.req = 4'b0001;
        tick();
        tick();
        chk("t5_zero_resp", 32'(bus.resp), 0);
        chk("t5_zero_busy", 32'(bus.busy), 0);
        bus.done = 1'b0;
        bus.req = '0;

        // 6: reset in the middle of a burst
        bus.req = 4'b0001;
        set_size(0, 0, 0, 3);
        tick();
        chk("t6_resp", 32'(bus.resp), 4'b0001);
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("t6_busy_mid", 32'(bus.busy), 1);
        bus.req = 4'b1111;
        set_size(1, 1, 1, 1);
        reset = 1'b0;
        #1;
        chk("t6_resp_rst", 32'(bus.resp), 0);
        chk("t6_start_rst", 32'(bus.start), 0);
        chk("t6_busy_rst", 32'(bus.busy), 0);
        chk("t6_abort_rst", 32'(bus.abort), 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
        chk("t6_first_win", 32'(bus.resp), 4'b0001);
        chk("t6_first_own", 32'(bus.owner), 0);
        bus.req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
